// File: rtl/sm83_irq_ctrl_if.sv
// Bus and dispatch-handshake bundle between the SM83 core and its interrupt controller.
// master: core side (drives strobes and handshake), slave: interrupt controller.
interface sm83_irq_ctrl_if;
  logic        if_wr;
  logic        ie_wr;
  logic [7:0]  wdata;
  logic [7:0]  if_rdata;
  logic [7:0]  ie_rdata;
  logic        irq_take;
  logic        irq_ack;
  logic        irq_done;
  logic [15:0] irq_vec;
  logic        irq_vec_valid;

  modport master (
    output if_wr, ie_wr, wdata, irq_ack, irq_done,
    input  if_rdata, ie_rdata, irq_take, irq_vec, irq_vec_valid
  );

  modport slave (
    input  if_wr, ie_wr, wdata, irq_ack, irq_done,
    output if_rdata, ie_rdata, irq_take, irq_vec, irq_vec_valid
  );
endinterface

// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: IF/IE/IME, EI/DI/RETI/HALT sequencing, fixed-priority
// dispatch. Optional macro SM83_HALT_BUG_EN adds the halt_bug output.
module sm83_irq_ctrl #(
  parameter int unsigned NUM_IRQ    = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_set,
  input  logic               ctl_ei,
  input  logic               ctl_di,
  input  logic               ctl_reti,
  input  logic               ctl_halt,
  input  logic               instr_boundary,
  output logic               halted,
  output logic               wake,
  output logic               ime,
`ifdef SM83_HALT_BUG_EN
  output logic               halt_bug,
`endif
  sm83_irq_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {StRun, StDispatch, StHalt} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] if_q, if_d, ie_q, ie_d;
  logic               ime_q, ime_d, ei_pend_q, ei_pend_d;
  logic [15:0]        vec_q, vec_d;
  logic               vec_valid_q, vec_valid_d;
  logic               halt_bug_q, halt_bug_d;

  logic [NUM_IRQ-1:0] pend, if_base, pend_ack;
  logic [2:0]         idx;
  logic [15:0]        vec_calc;
  logic               take, ack_fire, in_run;
  logic [7:0]         if_rd, ie_rd;
  logic               unused_wdata;

  assign unused_wdata = ^bus.wdata;

  // Pending set, priority pick and readback. The ack pick uses the post-write IF
  // so a same-cycle IF write of 0 cancels the dispatch.
  always_comb begin
    pend     = if_q & ie_q;
    if_base  = bus.if_wr ? bus.wdata[NUM_IRQ-1:0] : if_q;
    pend_ack = if_base & ie_q;
    idx      = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_ack[i]) idx = 3'(i);
    end
    vec_calc = VEC_BASE + 16'(32'(idx) * VEC_STRIDE);
    in_run   = (state_q == StRun);
    take     = in_run & ime_q & (|pend);
    ack_fire = bus.irq_ack & take;
    if_rd    = 8'hFF;
    if_rd[NUM_IRQ-1:0] = if_q;
    ie_rd    = 8'h00;
    ie_rd[NUM_IRQ-1:0] = ie_q;
  end

  assign bus.if_rdata      = if_rd;
  assign bus.ie_rdata      = ie_rd;
  assign bus.irq_take      = take;
  assign bus.irq_vec       = vec_q;
  assign bus.irq_vec_valid = vec_valid_q;
  assign halted            = (state_q == StHalt);
  assign wake              = (state_q == StHalt) & (|pend);
  assign ime               = ime_q;
`ifdef SM83_HALT_BUG_EN
  assign halt_bug          = halt_bug_q;
`endif

  // Next-state: FSM transitions, IF/IE updates and IME sequencing.
  always_comb begin
    state_d     = state_q;
    if_d        = if_base;
    ie_d        = bus.ie_wr ? bus.wdata[NUM_IRQ-1:0] : ie_q;
    ime_d       = ime_q;
    ei_pend_d   = ei_pend_q;
    vec_d       = vec_q;
    vec_valid_d = vec_valid_q;
    halt_bug_d  = 1'b0;

    unique case (state_q)
      StRun: begin
        if (ack_fire) begin
          state_d     = StDispatch;
          vec_valid_d = 1'b1;
          if (|pend_ack) begin
            vec_d     = vec_calc;
            if_d[idx] = 1'b0;
          end else begin
            vec_d = 16'h0000;
          end
        end else if (ctl_halt) begin
          if (ime_q || (pend == '0)) begin
            state_d = StHalt;
          end else begin
`ifdef SM83_HALT_BUG_EN
            halt_bug_d = 1'b1;
`endif
          end
        end
      end
      StDispatch: begin
        if (bus.irq_done) begin
          state_d     = StRun;
          vec_valid_d = 1'b0;
        end
      end
      StHalt: begin
        if (|pend) state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    // Set wins over both the bus write and the ack clear.
    if_d = if_d | irq_set;

    // EI takes effect one boundary late; later lines override earlier ones.
    if (instr_boundary && ei_pend_q) begin
      ime_d     = 1'b1;
      ei_pend_d = 1'b0;
    end
    if (in_run) begin
      if (ctl_ei)   ei_pend_d = 1'b1;
      if (ctl_reti) ime_d = 1'b1;
      if (ctl_di) begin
        ime_d     = 1'b0;
        ei_pend_d = 1'b0;
      end
    end
    if (ack_fire) begin
      ime_d     = 1'b0;
      ei_pend_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      if_q        <= '0;
      ie_q        <= '0;
      ime_q       <= 1'b0;
      ei_pend_q   <= 1'b0;
      vec_q       <= 16'h0000;
      vec_valid_q <= 1'b0;
      halt_bug_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      if_q        <= if_d;
      ie_q        <= ie_d;
      ime_q       <= ime_d;
      ei_pend_q   <= ei_pend_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      halt_bug_q  <= halt_bug_d;
    end
  end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Directed bench for sm83_irq_ctrl: default 5-source instance plus an 8-source,
// stride-16 instance for the collision/parameter case.
module tb_sm83_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] irq_set;
  logic       ctl_ei, ctl_di, ctl_reti, ctl_halt, instr_boundary;
  logic       halted, wake, ime;
  logic [7:0] irq_set8;
  logic       ctl8_reti;
  logic       halted8, wake8, ime8;
`ifdef SM83_HALT_BUG_EN
  logic       halt_bug, halt_bug8;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  sm83_irq_ctrl_if bus ();
  sm83_irq_ctrl_if bus8 ();

  always #5 clk = ~clk;

  sm83_irq_ctrl u_dut (
    .clk            (clk),
    .rst            (rst),
    .irq_set        (irq_set),
    .ctl_ei         (ctl_ei),
    .ctl_di         (ctl_di),
    .ctl_reti       (ctl_reti),
    .ctl_halt       (ctl_halt),
    .instr_boundary (instr_boundary),
    .halted         (halted),
    .wake           (wake),
    .ime            (ime),
`ifdef SM83_HALT_BUG_EN
    .halt_bug       (halt_bug),
`endif
    .bus            (bus)
  );

  sm83_irq_ctrl #(
    .NUM_IRQ    (8),
    .VEC_STRIDE (16)
  ) u_dut8 (
    .clk            (clk),
    .rst            (rst),
    .irq_set        (irq_set8),
    .ctl_ei         (1'b0),
    .ctl_di         (1'b0),
    .ctl_reti       (ctl8_reti),
    .ctl_halt       (1'b0),
    .instr_boundary (1'b0),
    .halted         (halted8),
    .wake           (wake8),
    .ime            (ime8),
`ifdef SM83_HALT_BUG_EN
    .halt_bug       (halt_bug8),
`endif
    .bus            (bus8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    irq_set = '0; irq_set8 = '0;
    ctl_ei = 0; ctl_di = 0; ctl_reti = 0; ctl_halt = 0; instr_boundary = 0; ctl8_reti = 0;
    bus.if_wr = 0; bus.ie_wr = 0; bus.wdata = '0; bus.irq_ack = 0; bus.irq_done = 0;
    bus8.if_wr = 0; bus8.ie_wr = 0; bus8.wdata = '0; bus8.irq_ack = 0; bus8.irq_done = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_if_rdata", 32'(bus.if_rdata), 32'hE0);
    chk("rst_ie_rdata", 32'(bus.ie_rdata), 32'h00);
    chk("rst_ime", 32'(ime), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_wake", 32'(wake), 32'h0);
    chk("rst_vec", 32'(bus.irq_vec), 32'h0000);
    chk("rst_vec_valid", 32'(bus.irq_vec_valid), 32'h0);
    chk("rst_take", 32'(bus.irq_take), 32'h0);
    chk("rst_if8_rdata", 32'(bus8.if_rdata), 32'h00);

    // Priority and vector
    bus.ie_wr = 1; bus.wdata = 8'h1F; tick(); bus.ie_wr = 0;
    bus.if_wr = 1; bus.wdata = 8'h14; tick(); bus.if_wr = 0;
    ctl_reti = 1; tick(); ctl_reti = 0;
    chk("prio_ime", 32'(ime), 32'h1);
    chk("prio_take", 32'(bus.irq_take), 32'h1);
    chk("prio_if", 32'(bus.if_rdata), 32'hF4);
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    chk("prio_vec1", 32'(bus.irq_vec), 32'h0050);
    chk("prio_valid1", 32'(bus.irq_vec_valid), 32'h1);
    chk("prio_if1", 32'(bus.if_rdata), 32'hF0);
    chk("prio_ime1", 32'(ime), 32'h0);
    chk("prio_take_disp", 32'(bus.irq_take), 32'h0);
    bus.irq_done = 1; tick(); bus.irq_done = 0;
    chk("prio_valid_done", 32'(bus.irq_vec_valid), 32'h0);
    chk("prio_vec_hold", 32'(bus.irq_vec), 32'h0050);
    ctl_reti = 1; tick(); ctl_reti = 0;
    chk("prio_take2", 32'(bus.irq_take), 32'h1);
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    chk("prio_vec2", 32'(bus.irq_vec), 32'h0060);
    chk("prio_if2", 32'(bus.if_rdata), 32'hE0);
    bus.irq_done = 1; tick(); bus.irq_done = 0;

    // EI delay
    bus.ie_wr = 1; bus.if_wr = 1; bus.wdata = 8'h01; tick(); bus.ie_wr = 0; bus.if_wr = 0;
    chk("ei_take0", 32'(bus.irq_take), 32'h0);
    ctl_ei = 1; tick(); ctl_ei = 0;
    chk("ei_ime_before", 32'(ime), 32'h0);
    instr_boundary = 1; #1;
    chk("ei_take_at_boundary", 32'(bus.irq_take), 32'h0);
    tick(); instr_boundary = 0;
    chk("ei_ime_after", 32'(ime), 32'h1);
    chk("ei_take_after", 32'(bus.irq_take), 32'h1);
    ctl_di = 1; tick(); ctl_di = 0;
    chk("di_ime", 32'(ime), 32'h0);
    ctl_ei = 1; tick(); ctl_ei = 0;
    ctl_di = 1; tick(); ctl_di = 0;
    instr_boundary = 1; tick(); instr_boundary = 0;
    chk("ei_di_ime", 32'(ime), 32'h0);

    // HALT wake with IME=0
    bus.if_wr = 1; bus.wdata = 8'h00; tick(); bus.if_wr = 0;
    bus.ie_wr = 1; bus.wdata = 8'h04; tick(); bus.ie_wr = 0;
    ctl_halt = 1; tick(); ctl_halt = 0;
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_wake0", 32'(wake), 32'h0);
    irq_set = 5'h04; tick(); irq_set = '0;
    chk("halt_wake1", 32'(wake), 32'h1);
    chk("halt_take_wake", 32'(bus.irq_take), 32'h0);
    tick();
    chk("halt_wake_end", 32'(wake), 32'h0);
    chk("halt_released", 32'(halted), 32'h0);
    chk("halt_take_after", 32'(bus.irq_take), 32'h0);
    chk("halt_if", 32'(bus.if_rdata), 32'hE4);

    // Cancellation
    bus.if_wr = 1; bus.ie_wr = 1; bus.wdata = 8'h02; tick(); bus.if_wr = 0; bus.ie_wr = 0;
    ctl_reti = 1; tick(); ctl_reti = 0;
    chk("cancel_take", 32'(bus.irq_take), 32'h1);
    bus.if_wr = 1; bus.wdata = 8'h00; bus.irq_ack = 1; tick();
    bus.if_wr = 0; bus.irq_ack = 0;
    chk("cancel_vec", 32'(bus.irq_vec), 32'h0000);
    chk("cancel_valid", 32'(bus.irq_vec_valid), 32'h1);
    chk("cancel_ime", 32'(ime), 32'h0);
    chk("cancel_if", 32'(bus.if_rdata), 32'hE0);
    bus.irq_done = 1; tick(); bus.irq_done = 0;
    chk("cancel_done", 32'(bus.irq_vec_valid), 32'h0);

    // Collision on 8-source, stride-16 instance
    bus8.ie_wr = 1; bus8.if_wr = 1; bus8.wdata = 8'h80; tick();
    bus8.ie_wr = 0; bus8.if_wr = 0;
    ctl8_reti = 1; tick(); ctl8_reti = 0;
    chk("coll_take", 32'(bus8.irq_take), 32'h1);
    bus8.irq_ack = 1; irq_set8 = 8'h80; tick(); bus8.irq_ack = 0; irq_set8 = '0;
    chk("coll_vec", 32'(bus8.irq_vec), 32'h00B0);
    chk("coll_if", 32'(bus8.if_rdata), 32'h80);
    chk("coll_valid", 32'(bus8.irq_vec_valid), 32'h1);
    chk("coll_ime", 32'(ime8), 32'h0);
    bus8.irq_done = 1; tick(); bus8.irq_done = 0;

    // HALT with IME=0 and a pending request: skipped (plus halt_bug when enabled)
    bus.if_wr = 1; bus.ie_wr = 1; bus.wdata = 8'h01; tick(); bus.if_wr = 0; bus.ie_wr = 0;
    ctl_halt = 1; tick(); ctl_halt = 0;
    chk("hbug_halted", 32'(halted), 32'h0);
`ifdef SM83_HALT_BUG_EN
    chk("hbug_pulse", 32'(halt_bug), 32'h1);
    tick();
    chk("hbug_pulse_end", 32'(halt_bug), 32'h0);
`endif

    // Reset during DISPATCH
    ctl_reti = 1; tick(); ctl_reti = 0;
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    chk("rstd_valid_pre", 32'(bus.irq_vec_valid), 32'h1);
    chk("rstd_vec_pre", 32'(bus.irq_vec), 32'h0040);
    rst = 1; tick(); rst = 0;
    chk("rstd_valid", 32'(bus.irq_vec_valid), 32'h0);
    chk("rstd_vec", 32'(bus.irq_vec), 32'h0000);
    chk("rstd_if", 32'(bus.if_rdata), 32'hE0);
    chk("rstd_ime", 32'(ime), 32'h0);
    // Back in RUN: HALT with nothing pending is accepted.
    ctl_halt = 1; tick(); ctl_halt = 0;
    chk("rstd_run_halt", 32'(halted), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
